// File: rtl/ysyx_22040759_mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encodings, load/store func3 codes
// and bit offsets of the EXE->MEM and MEM->WB buses.
package ysyx_22040759_mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } ms_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    // EXE->MEM bus fields
    localparam int IN_INST_LSB  = 141;
    localparam int IN_SRC2_LSB  = 77;
    localparam int IN_MEM_WEN   = 76;
    localparam int IN_MEM_REN   = 75;
    localparam int IN_FUNC3_LSB = 72;
    localparam int IN_WSEL_LSB  = 70;
    localparam int IN_REG_WEN   = 69;
    localparam int IN_RD_LSB    = 64;
    localparam int IN_PC_LSB    = 0;

    // MEM->WB bus fields
    localparam int OUT_INST_LSB = 136;
    localparam int OUT_RES_LSB  = 72;
    localparam int OUT_WSEL_LSB = 70;
    localparam int OUT_REG_WEN  = 69;
    localparam int OUT_RD_LSB   = 64;
    localparam int OUT_PC_LSB   = 0;

endpackage

// File: rtl/ysyx_22040759_mem_stage_if.sv
// Data-memory bridge handshake: req/gnt for the command, resp_valid for read
// data or write acknowledge.
interface ysyx_22040759_mem_stage_if #(
    parameter int XLEN = 64
);
    logic            req;
    logic            wr;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      wstrb;
    logic [2:0]      size;
    logic            gnt;
    logic            resp_valid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, wr, addr, wdata, wstrb, size,
        input  gnt, resp_valid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata, wstrb, size,
        output gnt, resp_valid, rdata
    );
endinterface

// File: rtl/ysyx_22040759_mem_stage_lsu_align.sv
// Combinational byte-lane logic: store data/strobe placement and load data
// extraction with sign or zero extension.
module ysyx_22040759_lsu_align
    import ysyx_22040759_mem_stage_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] src2_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] wdata_o,
    output logic [7:0]  wstrb_o,
    output logic [63:0] ldata_o
);
    logic [5:0]  shamt;
    logic [7:0]  strb_base;
    logic [63:0] shifted;

    assign shamt   = {off_i, 3'b000};
    assign wdata_o = src2_i << shamt;
    assign shifted = rdata_i >> shamt;

    always_comb begin
        strb_base = 8'h00;
        unique case (func3_i[1:0])
            2'd0: strb_base = 8'h01;
            2'd1: strb_base = 8'h03;
            2'd2: strb_base = 8'h0F;
            2'd3: strb_base = 8'hFF;
        endcase
    end

    // Misaligned strobes simply lose the bits shifted past lane 7
    assign wstrb_o = strb_base << off_i;

    always_comb begin
        ldata_o = shifted;
        case (func3_i)
            F3_B:    ldata_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    ldata_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    ldata_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    ldata_o = shifted;
            F3_BU:   ldata_o = {56'd0, shifted[7:0]};
            F3_HU:   ldata_o = {48'd0, shifted[15:0]};
            F3_WU:   ldata_o = {32'd0, shifted[31:0]};
            default: ldata_o = shifted;
        endcase
    end
endmodule

// File: rtl/ysyx_22040759_mem_stage.sv
// MEM pipeline stage: latches the EXE bus, performs one data-memory access per
// load/store and hands the final result to WB.
module ysyx_22040759_mem_stage
    import ysyx_22040759_mem_stage_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int IN_BUS_W  = 173,
    parameter int OUT_BUS_W = 168
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ws_allowin,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [IN_BUS_W-1:0]  es_to_ms_bus,
    input  logic [XLEN-1:0]      es_alu_result,
    output logic                 ms_to_ws_valid,
    output logic [OUT_BUS_W-1:0] ms_to_ws_bus,
    output logic [XLEN-1:0]      ms_alu_result,
    output logic [4:0]           ms_rd,
    output logic                 ms_is_load,
    ysyx_22040759_mem_stage_if.master dmem
);
    logic                ms_valid_q;
    logic [IN_BUS_W-1:0] bus_q;
    logic [XLEN-1:0]     alu_q;
    logic [XLEN-1:0]     ldata_q;
    ms_state_e           state_q;

    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic            in_mem_op;
    logic            ms_ready_go;
    logic            capture;
    logic            dmem_active;
    logic [2:0]      func3;
    logic [XLEN-1:0] st_wdata;
    logic [7:0]      st_wstrb;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] final_result;

    assign is_load   = bus_q[IN_MEM_REN];
    assign is_store  = bus_q[IN_MEM_WEN];
    assign mem_op    = is_load | is_store;
    assign in_mem_op = es_to_ms_bus[IN_MEM_REN] | es_to_ms_bus[IN_MEM_WEN];
    assign func3     = bus_q[IN_FUNC3_LSB +: 3];

    assign ms_ready_go    = !mem_op || (state_q == ST_DONE);
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign capture        = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            alu_q      <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (capture) begin
                bus_q <= es_to_ms_bus;
                alu_q <= es_alu_result;
            end
        end
    end

    // A response that arrives outside RESP (e.g. after a reset) never advances the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ldata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture && in_mem_op) state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (dmem.gnt) state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (dmem.resp_valid) begin
                        if (is_load) ldata_q <= ld_data;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ms_allowin) state_q <= (capture && in_mem_op) ? ST_REQ : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ysyx_22040759_lsu_align u_align (
        .func3_i (func3),
        .off_i   (alu_q[2:0]),
        .src2_i  (bus_q[IN_SRC2_LSB +: 64]),
        .rdata_i (dmem.rdata),
        .wdata_o (st_wdata),
        .wstrb_o (st_wstrb),
        .ldata_o (ld_data)
    );

    assign dmem_active = (state_q == ST_REQ);
    assign dmem.req    = dmem_active;
    assign dmem.wr     = dmem_active && is_store;
    assign dmem.addr   = dmem_active ? alu_q : '0;
    assign dmem.wdata  = (dmem_active && is_store) ? st_wdata : '0;
    assign dmem.wstrb  = (dmem_active && is_store) ? st_wstrb : 8'h00;
    assign dmem.size   = dmem_active ? {1'b0, func3[1:0]} : 3'b000;

    assign final_result = is_load ? ldata_q : alu_q;

    assign ms_to_ws_bus = {bus_q[IN_INST_LSB +: 32],
                           final_result,
                           bus_q[IN_WSEL_LSB +: 2],
                           bus_q[IN_REG_WEN],
                           bus_q[IN_RD_LSB +: 5],
                           bus_q[IN_PC_LSB +: 64]};

    assign ms_alu_result = alu_q;
    assign ms_rd         = (ms_valid_q && bus_q[IN_REG_WEN]) ? bus_q[IN_RD_LSB +: 5] : 5'd0;
    assign ms_is_load    = ms_valid_q && is_load;
endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Scoreboard bench for the MEM stage: directed instructions, a configurable
// data-memory responder, and monitors for WB output and memory requests.
module tb_ysyx_22040759_mem_stage;
    import ysyx_22040759_mem_stage_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [2:0]  size;
    } req_t;

    logic         clk;
    logic         rst;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [172:0] es_to_ms_bus;
    logic [63:0]  es_alu_result;
    logic         ms_to_ws_valid;
    logic [167:0] ms_to_ws_bus;
    logic [63:0]  ms_alu_result;
    logic [4:0]   ms_rd;
    logic         ms_is_load;

    ysyx_22040759_mem_stage_if #(.XLEN(64)) dmem ();

    ysyx_22040759_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .es_alu_result  (es_alu_result),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_alu_result  (ms_alu_result),
        .ms_rd          (ms_rd),
        .ms_is_load     (ms_is_load),
        .dmem           (dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           testsRun    = 0;
    int           testsFailed = 0;
    logic [167:0] wbQ[$];
    req_t         reqQ[$];
    req_t         curReq      = '0;
    bit           reqActive   = 1'b0;
    int           reqCount    = 0;
    int           gntDelay    = 0;
    int           respDelay   = 0;
    int           gntWait     = 0;
    int           respCnt     = 0;
    bit           respPending = 1'b0;
    logic [63:0]  memRdata    = '0;

    task automatic checkOutput(input string name, input logic [167:0] actual, input logic [167:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected orderly completion", name);
    endtask

    function automatic logic [172:0] makeBus(input logic [31:0] inst, input logic [63:0] src2,
                                             input logic wen, input logic ren, input logic [2:0] f3,
                                             input logic [1:0] wsel, input logic regWen,
                                             input logic [4:0] rd, input logic [63:0] pc);
        return {inst, src2, wen, ren, f3, wsel, regWen, rd, pc};
    endfunction

    function automatic logic [167:0] makeWb(input logic [31:0] inst, input logic [63:0] res,
                                            input logic [1:0] wsel, input logic regWen,
                                            input logic [4:0] rd, input logic [63:0] pc);
        return {inst, res, wsel, regWen, rd, pc};
    endfunction

    task automatic expectReq(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wstrb, input logic [2:0] size);
        req_t r;
        r.wr = wr; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb; r.size = size;
        reqQ.push_back(r);
    endtask

    // Memory responder: grant after gntDelay cycles of req, respond respDelay cycles later
    always @(negedge clk) begin
        dmem.gnt        = 1'b0;
        dmem.resp_valid = 1'b0;
        if (respPending) begin
            if (respCnt == 0) begin
                dmem.resp_valid = 1'b1;
                dmem.rdata      = memRdata;
                respPending     = 1'b0;
            end else begin
                respCnt--;
            end
        end
        if (dmem.req) begin
            if (gntWait < gntDelay) begin
                gntWait++;
            end else begin
                dmem.gnt    = 1'b1;
                gntWait     = 0;
                respPending = 1'b1;
                respCnt     = respDelay;
            end
        end
    end

    // Request monitor: payload must match expectation on every cycle req is held
    always @(negedge clk) begin
        if (dmem.req && !reqActive) begin
            reqCount++;
            reqActive = 1'b1;
            if (reqQ.size() == 0) failNow("unexpected_dmem_req");
            else curReq = reqQ.pop_front();
        end
        if (dmem.req) begin
            checkOutput("dmem_wr",    168'(dmem.wr),    168'(curReq.wr));
            checkOutput("dmem_addr",  168'(dmem.addr),  168'(curReq.addr));
            checkOutput("dmem_wdata", 168'(dmem.wdata), 168'(curReq.wdata));
            checkOutput("dmem_wstrb", 168'(dmem.wstrb), 168'(curReq.wstrb));
            checkOutput("dmem_size",  168'(dmem.size),  168'(curReq.size));
        end else begin
            reqActive = 1'b0;
        end
    end

    // WB monitor: every transfer to WB pops one expected bus
    always @(negedge clk) begin
        logic [167:0] exp;
        if (rst && ms_to_ws_valid && ws_allowin) begin
            if (wbQ.size() == 0) begin
                failNow("unexpected_wb_output");
            end else begin
                exp = wbQ.pop_front();
                checkOutput("wb_bus", ms_to_ws_bus, exp);
            end
        end
    end

    task automatic applyStimulus(input logic [172:0] bus, input logic [63:0] alu);
        bit done;
        done           = 1'b0;
        es_to_ms_bus   = bus;
        es_alu_result  = alu;
        es_to_ms_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = ms_allowin;
            @(posedge clk);
            #1;
        end
        es_to_ms_valid = 1'b0;
        if (!done) failNow("capture_timeout");
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (wbQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (wbQ.size() != 0) failNow(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [172:0] bus;
        logic [172:0] ldBus;
        int           n;

        rst             = 1'b0;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        es_alu_result   = '0;
        dmem.gnt        = 1'b0;
        dmem.resp_valid = 1'b0;
        dmem.rdata      = '0;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("rst_allowin",   168'(ms_allowin),     168'(1));
        checkOutput("rst_wb_valid",  168'(ms_to_ws_valid), 168'(0));
        checkOutput("rst_wb_bus",    ms_to_ws_bus,         168'(0));
        checkOutput("rst_alu",       168'(ms_alu_result),  168'(0));
        checkOutput("rst_rd",        168'(ms_rd),          168'(0));
        checkOutput("rst_is_load",   168'(ms_is_load),     168'(0));
        checkOutput("rst_req",       168'(dmem.req),       168'(0));
        checkOutput("rst_wstrb",     168'(dmem.wstrb),     168'(0));
        checkOutput("rst_size",      168'(dmem.size),      168'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Non-memory ADD
        bus = makeBus(32'h00b50533, 64'h0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd10, 64'h8000_0000);
        wbQ.push_back(makeWb(32'h00b50533, 64'h1234, 2'd0, 1'b1, 5'd10, 64'h8000_0000));
        applyStimulus(bus, 64'h1234);
        checkOutput("add_valid_next", 168'(ms_to_ws_valid), 168'(1));
        checkOutput("add_alu_fwd",    168'(ms_alu_result),  168'(64'h1234));
        checkOutput("add_rd_fwd",     168'(ms_rd),          168'(10));
        waitDrain("add_drain");
        checkOutput("add_no_req", 168'(reqCount), 168'(0));

        // LB sign extension
        gntDelay = 0; respDelay = 1; memRdata = 64'h0000_0000_8000_0000;
        bus = makeBus(32'h00300283, 64'h0, 1'b0, 1'b1, F3_B, 2'd1, 1'b1, 5'd5, 64'h8000_0004);
        expectReq(1'b0, 64'h8000_0003, 64'h0, 8'h00, 3'd0);
        wbQ.push_back(makeWb(32'h00300283, 64'hFFFF_FFFF_FFFF_FF80, 2'd1, 1'b1, 5'd5, 64'h8000_0004));
        applyStimulus(bus, 64'h8000_0003);
        checkOutput("lb_not_ready", 168'(ms_to_ws_valid), 168'(0));
        waitDrain("lb_drain");

        // LBU with a slow grant, checking hazard outputs in REQ
        gntDelay = 2;
        bus = makeBus(32'h00304283, 64'h0, 1'b0, 1'b1, F3_BU, 2'd1, 1'b1, 5'd5, 64'h8000_0008);
        expectReq(1'b0, 64'h8000_0003, 64'h0, 8'h00, 3'd0);
        wbQ.push_back(makeWb(32'h00304283, 64'h80, 2'd1, 1'b1, 5'd5, 64'h8000_0008));
        applyStimulus(bus, 64'h8000_0003);
        checkOutput("lbu_req",     168'(dmem.req),   168'(1));
        checkOutput("lbu_is_load", 168'(ms_is_load), 168'(1));
        checkOutput("lbu_rd",      168'(ms_rd),      168'(5));
        waitDrain("lbu_drain");

        // LH with reg_wen=0 hides rd from the hazard unit
        gntDelay = 0; respDelay = 0;
        bus = makeBus(32'h00201383, 64'h0, 1'b0, 1'b1, F3_H, 2'd1, 1'b0, 5'd7, 64'h8000_000C);
        expectReq(1'b0, 64'h8000_0002, 64'h0, 8'h00, 3'd1);
        wbQ.push_back(makeWb(32'h00201383, 64'hFFFF_FFFF_FFFF_8000, 2'd1, 1'b0, 5'd7, 64'h8000_000C));
        applyStimulus(bus, 64'h8000_0002);
        checkOutput("lh_rd_masked", 168'(ms_rd),      168'(0));
        checkOutput("lh_is_load",   168'(ms_is_load), 168'(1));
        waitDrain("lh_drain");

        // LW / LWU / LHU on an upper-lane word
        memRdata = 64'h8765_4321_0000_0000;
        bus = makeBus(32'h00402303, 64'h0, 1'b0, 1'b1, F3_W, 2'd1, 1'b1, 5'd6, 64'h8000_0010);
        expectReq(1'b0, 64'h8000_0004, 64'h0, 8'h00, 3'd2);
        wbQ.push_back(makeWb(32'h00402303, 64'hFFFF_FFFF_8765_4321, 2'd1, 1'b1, 5'd6, 64'h8000_0010));
        applyStimulus(bus, 64'h8000_0004);
        waitDrain("lw_drain");
        bus = makeBus(32'h00406303, 64'h0, 1'b0, 1'b1, F3_WU, 2'd1, 1'b1, 5'd6, 64'h8000_0014);
        expectReq(1'b0, 64'h8000_0004, 64'h0, 8'h00, 3'd2);
        wbQ.push_back(makeWb(32'h00406303, 64'h0000_0000_8765_4321, 2'd1, 1'b1, 5'd6, 64'h8000_0014));
        applyStimulus(bus, 64'h8000_0004);
        waitDrain("lwu_drain");
        bus = makeBus(32'h00605303, 64'h0, 1'b0, 1'b1, F3_HU, 2'd1, 1'b1, 5'd6, 64'h8000_0018);
        expectReq(1'b0, 64'h8000_0006, 64'h0, 8'h00, 3'd1);
        wbQ.push_back(makeWb(32'h00605303, 64'h8765, 2'd1, 1'b1, 5'd6, 64'h8000_0018));
        applyStimulus(bus, 64'h8000_0006);
        waitDrain("lhu_drain");

        // SH with a grant held off three cycles; monitor checks payload every cycle
        gntDelay = 3;
        bus = makeBus(32'h00f11323, 64'hBEEF, 1'b1, 1'b0, F3_H, 2'd0, 1'b0, 5'd0, 64'h8000_001C);
        expectReq(1'b1, 64'h8000_0006, 64'hBEEF_0000_0000_0000, 8'hC0, 3'd1);
        wbQ.push_back(makeWb(32'h00f11323, 64'h8000_0006, 2'd0, 1'b0, 5'd0, 64'h8000_001C));
        applyStimulus(bus, 64'h8000_0006);
        for (int i = 0; i < 3; i++) begin
            checkOutput("sh_req_held", 168'(dmem.req), 168'(1));
            checkOutput("sh_wr_held",  168'(dmem.wr),  168'(1));
            @(posedge clk);
            #1;
        end
        waitDrain("sh_drain");

        // Misaligned SW, full SD, top-lane SB
        gntDelay = 0;
        bus = makeBus(32'h00e122a3, 64'h1122_3344, 1'b1, 1'b0, F3_W, 2'd0, 1'b0, 5'd0, 64'h8000_0020);
        expectReq(1'b1, 64'h105, 64'h2233_4400_0000_0000, 8'hE0, 3'd2);
        wbQ.push_back(makeWb(32'h00e122a3, 64'h105, 2'd0, 1'b0, 5'd0, 64'h8000_0020));
        applyStimulus(bus, 64'h105);
        waitDrain("sw_drain");
        bus = makeBus(32'h00e13823, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, F3_D, 2'd0, 1'b0, 5'd0, 64'h8000_0024);
        expectReq(1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'd3);
        wbQ.push_back(makeWb(32'h00e13823, 64'h10, 2'd0, 1'b0, 5'd0, 64'h8000_0024));
        applyStimulus(bus, 64'h10);
        waitDrain("sd_drain");
        bus = makeBus(32'h00e103a3, 64'h1234_5678_9ABC_DEAB, 1'b1, 1'b0, F3_B, 2'd0, 1'b0, 5'd0, 64'h8000_0028);
        expectReq(1'b1, 64'h7, 64'hAB00_0000_0000_0000, 8'h80, 3'd0);
        wbQ.push_back(makeWb(32'h00e103a3, 64'h7, 2'd0, 1'b0, 5'd0, 64'h8000_0028));
        applyStimulus(bus, 64'h7);
        waitDrain("sb_drain");

        // Back-pressure: LW parks in DONE while an LD waits on the EXE bus
        respDelay = 0; memRdata = 64'h8765_4321_0000_0000;
        ws_allowin = 1'b0;
        bus   = makeBus(32'h00402403, 64'h0, 1'b0, 1'b1, F3_W, 2'd1, 1'b1, 5'd8, 64'h8000_0030);
        ldBus = makeBus(32'h00803483, 64'h0, 1'b0, 1'b1, F3_D, 2'd1, 1'b1, 5'd9, 64'h8000_0034);
        expectReq(1'b0, 64'h4, 64'h0, 8'h00, 3'd2);
        wbQ.push_back(makeWb(32'h00402403, 64'hFFFF_FFFF_8765_4321, 2'd1, 1'b1, 5'd8, 64'h8000_0030));
        applyStimulus(bus, 64'h4);
        es_to_ms_bus   = ldBus;
        es_alu_result  = 64'h8;
        es_to_ms_valid = 1'b1;
        n = 0;
        while (!ms_to_ws_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ms_to_ws_valid) failNow("bp_done_timeout");
        memRdata = 64'h0123_4567_89AB_CDEF;
        expectReq(1'b0, 64'h8, 64'h0, 8'h00, 3'd3);
        wbQ.push_back(makeWb(32'h00803483, 64'h0123_4567_89AB_CDEF, 2'd1, 1'b1, 5'd9, 64'h8000_0034));
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_allowin", 168'(ms_allowin), 168'(0));
            checkOutput("bp_valid",   168'(ms_to_ws_valid), 168'(1));
            checkOutput("bp_held",    168'(ms_to_ws_bus[OUT_RES_LSB +: 64]), 168'(64'hFFFF_FFFF_8765_4321));
            checkOutput("bp_no_req",  168'(dmem.req), 168'(0));
            @(posedge clk);
            #1;
        end
        ws_allowin = 1'b1;
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        checkOutput("bp_ld_req",  168'(dmem.req),   168'(1));
        checkOutput("bp_ld_load", 168'(ms_is_load), 168'(1));
        checkOutput("bp_ld_rd",   168'(ms_rd),      168'(9));
        waitDrain("bp_drain");

        // Reset during RESP; the late response must be dropped
        gntDelay = 0; respDelay = 3;
        bus = makeBus(32'h00803503, 64'h0, 1'b0, 1'b1, F3_D, 2'd1, 1'b1, 5'd10, 64'h8000_0038);
        expectReq(1'b0, 64'h8, 64'h0, 8'h00, 3'd3);
        applyStimulus(bus, 64'h8);
        n = 0;
        while (!(respPending && !dmem.req) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(respPending && !dmem.req)) failNow("rst_resp_state_timeout");
        rst = 1'b0;
        #1;
        checkOutput("midrst_allowin", 168'(ms_allowin),     168'(1));
        checkOutput("midrst_valid",   168'(ms_to_ws_valid), 168'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("postrst_valid",   168'(ms_to_ws_valid), 168'(0));
            checkOutput("postrst_req",     168'(dmem.req),       168'(0));
            checkOutput("postrst_is_load", 168'(ms_is_load),     168'(0));
            checkOutput("postrst_allowin", 168'(ms_allowin),     168'(1));
            @(posedge clk);
            #1;
        end

        // Stage recovers with a plain ALU op
        bus = makeBus(32'h00a58633, 64'h0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd12, 64'h8000_003C);
        wbQ.push_back(makeWb(32'h00a58633, 64'hCAFE, 2'd0, 1'b1, 5'd12, 64'h8000_003C));
        applyStimulus(bus, 64'hCAFE);
        waitDrain("final_drain");
        repeat (2) @(posedge clk);
        #1;

        checkOutput("wbq_empty",  168'(wbQ.size()),  168'(0));
        checkOutput("reqq_empty", 168'(reqQ.size()), 168'(0));
        checkOutput("req_total",  168'(reqCount),    168'(13));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/ysyx_22040759_mem_stage.md
Name: ysyx_22040759_mem_stage

Overview:
- Memory-access pipeline stage between EXE and WB.
- Latches the EXE bus and ALU result, issues one load/store per instruction to the data-memory bridge over a req/gnt + response handshake, and aligns and sign-extends load data.
- Forwards the final result to WB and exposes hazard/forwarding info to the hazard unit.

Parameters:
- XLEN, 64, datapath width
- IN_BUS_W, 173, EXE->MEM bus width
- OUT_BUS_W, 168, MEM->WB bus width

Ports:
- clk  in  1  clock; all flops rising-edge
- rst  in  1  reset; asynchronous, active-low
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  EXE bus valid
- es_to_ms_bus  in  173  [172:141] inst, [140:77] store data, [76] mem_wen, [75] mem_ren, [74:72] func3, [71:70] wreg_sel, [69] reg_wen, [68:64] rd, [63:0] pc
- es_alu_result  in  64  ALU result / effective address
- ms_to_ws_valid  out  1  WB bus valid
- ms_to_ws_bus  out  168  [167:136] inst, [135:72] final result, [71:70] wreg_sel, [69] reg_wen, [68:64] rd, [63:0] pc
- ms_alu_result  out  64  latched ALU result, for EXE forwarding
- ms_rd  out  5  rd when ms_valid&&reg_wen, else 0
- ms_is_load  out  1  ms_valid && mem_ren (load-use stall)
- dmem_req  out  1  request valid
- dmem_wr  out  1  1 = store
- dmem_addr  out  64  byte address = latched ALU result
- dmem_wdata  out  64  store data shifted to byte lane
- dmem_wstrb  out  8  byte strobes
- dmem_size  out  3  func3[1:0] zero-extended (0=B, 1=H, 2=W, 3=D)
- dmem_gnt  in  1  request accepted
- dmem_resp_valid  in  1  read data / write ack valid
- dmem_rdata  in  64  aligned 64-bit read word

Behaviour:
- Reset (rst=0, async): ms_valid=0, state=IDLE, bus register=0, load-data register=0. All outputs are 0 except ms_allowin=1.
- Pipeline handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - When ms_allowin, ms_valid <= es_to_ms_valid.
  - Bus and ALU result are captured only when es_to_ms_valid && ms_allowin; otherwise they hold.
- mem_op = mem_ren | mem_wen of the latched instruction.
- ms_ready_go = !mem_op || state==DONE.
- FSM states IDLE, REQ, RESP, DONE:
  - IDLE: on capture of a valid mem_op -> REQ; otherwise stay.
  - REQ: dmem_req=1 and dmem_wr/addr/wdata/wstrb/size stable until dmem_gnt. On gnt -> RESP.
  - RESP: on dmem_resp_valid, capture dmem_rdata (loads only) -> DONE.
  - DONE: result held while !ws_allowin. On advance: if a new valid mem_op is captured the same cycle -> REQ, else -> IDLE.
- Non-memory instructions pass in 1 cycle with no bus activity.
- Load latency: at least 3 cycles in stage (REQ+gnt, RESP+resp, DONE).
- dmem_resp_valid in IDLE/REQ/DONE is ignored; a response arriving after a mid-operation reset is dropped.
- Stores:
  - off = addr[2:0]; wdata = src2 << (8*off).
  - wstrb = {1,3,0xF,0xFF}[size] << off.
  - final result = alu_result.
- Loads:
  - shifted = rdata >> (8*off).
  - func3 0/1/2/3 = LB/LH/LW/LD, sign-extended; 4/5/6 = LBU/LHU/LWU, zero-extended.
- Misaligned addresses are not trapped; the shift/strobe rules above apply verbatim, and strobe bits beyond bit 7 are discarded.
- final result = load ? extended data : alu_result.
- reg_wen and wreg_sel pass through unchanged.

Decomposition:
- Shared define file gets:
  - FSM state encodings (2-bit).
  - func3 load/store codes.
  - Bus field offsets for both buses.
- One sub-module, ysyx_22040759_lsu_align (combinational): store lane shift + strobe, and load shift + extension.
- The FSM and pipeline register stay in the top module.

Test Plan:
- Non-mem ADD: bus mem_ren=mem_wen=0, alu_result=0x1234, ws_allowin=1 -> ms_to_ws_valid the next cycle, result 0x1234, dmem_req never asserted.
- LB from addr 0x80000003, rdata=0x0000_0000_8000_0000, gnt in REQ cycle 1, resp 2 cycles later -> result 0xFFFF_FFFF_FFFF_FF80; LBU on the same word gives 0x80.
- SH of src2=0xBEEF to addr 0x...6 -> dmem_wdata=0xBEEF_0000_0000_0000, wstrb=0xC0, dmem_wr=1. Hold gnt low 3 cycles -> req and payload remain stable.
- Back-pressure: load reaches DONE with ws_allowin=0 for 4 cycles -> ms_allowin=0, result held, no new request. On release, a queued LD is captured the same cycle and state goes to REQ.
- Reset asserted in RESP, then resp_valid pulses after reset release -> state IDLE, ms_valid=0, response ignored, no WB output.
- Hazard outputs: load with rd=5 in REQ -> ms_is_load=1, ms_rd=5. With reg_wen=0 -> ms_rd=0.
